// File: rtl/alu_sequencer.sv
// Sequencer driving the alu_datapath store_a/store_b/start/done protocol from a
// valid/ready command port and returning result/overflow on a valid/ready response port.
// Optional ALU_SEQ_STATS_EN adds saturating response/overflow/timeout counters.
module alu_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [1:0]            cmd_opcode,
    output logic [DATA_WIDTH-1:0] alu_data,
    output logic [1:0]            opcode_value,
    output logic                  store_a,
    output logic                  store_b,
    output logic                  start,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow_def,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]           stat_ops,
    output logic [15:0]           stat_ovf,
    output logic [15:0]           stat_tmo
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DRAIN  = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
    logic [1:0]            opcode_q, opcode_d;
    logic                  store_a_q, store_a_d;
    logic                  store_b_q, store_b_d;
    logic                  start_q, start_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_ovf_q, rsp_ovf_d;
    logic                  rsp_tmo_q, rsp_tmo_d;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_ovf_q, stat_ovf_d;
    logic [15:0] stat_tmo_q, stat_tmo_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Outputs are computed one cycle ahead from the next state so every port is a flop.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = 1'b0;
        b_d          = b_q;
        alu_data_d   = alu_data_q;
        opcode_d     = opcode_q;
        store_a_d    = 1'b0;
        store_b_d    = 1'b0;
        start_d      = 1'b0;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_tmo_d    = rsp_tmo_q;
`ifdef ALU_SEQ_STATS_EN
        stat_ops_d   = stat_ops_q;
        stat_ovf_d   = stat_ovf_q;
        stat_tmo_d   = stat_tmo_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = LOAD_A;
                    cmd_ready_d = 1'b0;
                    store_a_d   = 1'b1;
                    alu_data_d  = cmd_a;
                    opcode_d    = cmd_opcode;
                    b_d         = cmd_b;
                end
            end
            LOAD_A: begin
                state_d    = LOAD_B;
                store_b_d  = 1'b1;
                alu_data_d = b_q;
            end
            LOAD_B: begin
                state_d = EXEC;
                start_d = 1'b1;
                cnt_d   = '0;
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done arriving on the last allowed cycle still counts as success.
                if (alu_done) begin
                    state_d      = DRAIN;
                    rsp_result_d = result;
                    rsp_ovf_d    = overflow_def;
                    rsp_tmo_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = DRAIN;
                    rsp_result_d = '0;
                    rsp_ovf_d    = 1'b0;
                    rsp_tmo_d    = 1'b1;
                end else begin
                    start_d = 1'b1;
                end
            end
            DRAIN: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
`ifdef ALU_SEQ_STATS_EN
                    stat_ops_d  = sat_inc(stat_ops_q);
                    if (rsp_ovf_q) stat_ovf_d = sat_inc(stat_ovf_q);
                    if (rsp_tmo_q) stat_tmo_d = sat_inc(stat_tmo_q);
`endif
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            b_q          <= '0;
            alu_data_q   <= '0;
            opcode_q     <= '0;
            store_a_q    <= 1'b0;
            store_b_q    <= 1'b0;
            start_q      <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_tmo_q    <= 1'b0;
`ifdef ALU_SEQ_STATS_EN
            stat_ops_q   <= '0;
            stat_ovf_q   <= '0;
            stat_tmo_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            b_q          <= b_d;
            alu_data_q   <= alu_data_d;
            opcode_q     <= opcode_d;
            store_a_q    <= store_a_d;
            store_b_q    <= store_b_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_tmo_q    <= rsp_tmo_d;
`ifdef ALU_SEQ_STATS_EN
            stat_ops_q   <= stat_ops_d;
            stat_ovf_q   <= stat_ovf_d;
            stat_tmo_q   <= stat_tmo_d;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign alu_data     = alu_data_q;
    assign opcode_value = opcode_q;
    assign store_a      = store_a_q;
    assign store_b      = store_b_q;
    assign start        = start_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_timeout  = rsp_tmo_q;
`ifdef ALU_SEQ_STATS_EN
    assign stat_ops     = stat_ops_q;
    assign stat_ovf     = stat_ovf_q;
    assign stat_tmo     = stat_tmo_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural datapath answers start with a configurable
// done delay; a scoreboard queue holds expected responses per accepted command.
module tb_alu_sequencer;

    localparam int TMO = 64;
    localparam logic [24:0] RST_VAL = {1'b1, 24'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic [1:0]  cmd_opcode = 2'd0;
    logic [7:0]  alu_data;
    logic [1:0]  opcode_value;
    logic        store_a, store_b, start;
    logic        alu_done = 1'b0;
    logic [7:0]  result = 8'h00;
    logic        overflow_def = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_result;
    logic        rsp_overflow, rsp_timeout;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_ovf, stat_tmo;
`endif

    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] a_buf = 8'h00;
    logic [7:0] b_buf = 8'h00;
    int         m_cnt = 0;
    int         m_dly = 2;
    bit         m_never = 1'b0;

    alu_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
        .alu_data(alu_data), .opcode_value(opcode_value),
        .store_a(store_a), .store_b(store_b), .start(start),
        .alu_done(alu_done), .result(result), .overflow_def(overflow_def),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout)
`ifdef ALU_SEQ_STATS_EN
        , .stat_ops(stat_ops), .stat_ovf(stat_ovf), .stat_tmo(stat_tmo)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {(a < b), a - b};
            2'd2:    return {8'h00, ^{a, b}};
            default: return {1'b0, (a == b) ? 8'hFF : 8'h00};
        endcase
    endfunction

    // Datapath model: done rises m_dly cycles after start first appears, drops when start drops.
    always @(posedge clk) begin
        if (store_a) a_buf <= alu_data;
        if (store_b) b_buf <= alu_data;
        if (reset || !start) begin
            m_cnt    <= 0;
            alu_done <= 1'b0;
        end else if (!alu_done) begin
            m_cnt <= m_cnt + 1;
            if (!m_never && (m_cnt + 1 >= m_dly)) begin
                alu_done <= 1'b1;
                {overflow_def, result} <= ref_alu(a_buf, b_buf, opcode_value);
            end
        end
    end

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input int dly, input bit never, input int hold);
        exp_t       e;
        logic [8:0] r;
        int         w;
        int         lat;
        int         n_exec;
        m_dly   = dly;
        m_never = never;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL cmd_ready_wait got %b want 1", cmd_ready);
        end
        if (never) begin
            e = '{res: 8'h00, ovf: 1'b0, tmo: 1'b1};
            n_exec = TMO;
        end else begin
            r = ref_alu(a, b, op);
            e = '{res: r[7:0], ovf: r[8], tmo: 1'b0};
            n_exec = dly + 1;
        end
        sb.push_back(e);
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        n_vec++;
        if ({cmd_ready, store_a, store_b, start, alu_data, opcode_value} !== {4'b0100, a, op}) begin
            n_err++; $display("FAIL load_a got %b_%b%b%b_%h_%0d want 0_100_%h_%0d",
                              cmd_ready, store_a, store_b, start, alu_data, opcode_value, a, op);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({cmd_ready, store_a, store_b, start, alu_data, opcode_value} !== {4'b0010, b, op}) begin
            n_err++; $display("FAIL load_b got %b_%b%b%b_%h_%0d want 0_010_%h_%0d",
                              cmd_ready, store_a, store_b, start, alu_data, opcode_value, b, op);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({cmd_ready, store_a, store_b, start, alu_data, opcode_value} !== {4'b0001, b, op}) begin
            n_err++; $display("FAIL exec got %b_%b%b%b_%h_%0d want 0_001_%h_%0d",
                              cmd_ready, store_a, store_b, start, alu_data, opcode_value, b, op);
        end
        lat = 3;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        n_vec++;
        if (lat !== 4 + n_exec) begin
            n_err++; $display("FAIL latency got %0d want %0d", lat, 4 + n_exec);
        end
        n_vec++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if ({rsp_valid, rsp_result, rsp_overflow, rsp_timeout, store_a, store_b, start, cmd_ready}
                !== {1'b1, e.res, e.ovf, e.tmo, 4'b0000}) begin
                n_err++; $display("FAIL rsp got v=%b r=%h o=%b t=%b ctl=%b%b%b%b want v=1 r=%h o=%b t=%b ctl=0000",
                                  rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
                                  store_a, store_b, start, cmd_ready, e.res, e.ovf, e.tmo);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({rsp_valid, rsp_result, rsp_overflow, rsp_timeout, cmd_ready}
                !== {1'b1, e.res, e.ovf, e.tmo, 1'b0}) begin
                n_err++; $display("FAIL rsp_hold[%0d] got v=%b r=%h o=%b t=%b rdy=%b want v=1 r=%h o=%b t=%b rdy=0",
                                  i, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, cmd_ready,
                                  e.res, e.ovf, e.tmo);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_err++; $display("FAIL rsp_done got valid=%b ready=%b want valid=0 ready=1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({cmd_ready, store_a, store_b, start, alu_data, opcode_value, rsp_valid,
             rsp_result, rsp_overflow, rsp_timeout} !== RST_VAL) begin
            n_err++; $display("FAIL reset_state got %h want %h",
                              {cmd_ready, store_a, store_b, start, alu_data, opcode_value,
                               rsp_valid, rsp_result, rsp_overflow, rsp_timeout}, RST_VAL);
        end
`ifdef ALU_SEQ_STATS_EN
        n_vec++;
        if ({stat_ops, stat_ovf, stat_tmo} !== 48'h0) begin
            n_err++; $display("FAIL reset_stats got %h want 0", {stat_ops, stat_ovf, stat_tmo});
        end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({cmd_ready, rsp_valid, start} !== 3'b100) begin
            n_err++; $display("FAIL post_reset got %b want 100", {cmd_ready, rsp_valid, start});
        end
    endtask

    task automatic test_add();
        do_cmd(8'h05, 8'h03, 2'd0, 2, 1'b0, 0);
    endtask

    task automatic test_overflow();
        do_cmd(8'hFF, 8'h01, 2'd0, 2, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        do_cmd(8'hA5, 8'hA5, 2'd3, 3, 1'b0, 10);
    endtask

    task automatic test_timeout();
        do_cmd(8'h12, 8'h34, 2'd0, 0, 1'b1, 0);
        do_cmd(8'h0F, 8'h01, 2'd2, 2, 1'b0, 0);
    endtask

    task automatic test_done_on_last_cycle();
        do_cmd(8'h40, 8'h02, 2'd1, TMO - 1, 1'b0, 0);
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        m_dly = 20; m_never = 1'b0;
        cmd_a = 8'h33; cmd_b = 8'h44; cmd_opcode = 2'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (start !== 1'b1) begin
            n_err++; $display("FAIL mid_exec_start got %b want 1", start);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++;
        if ({cmd_ready, store_a, store_b, start, alu_data, opcode_value, rsp_valid,
             rsp_result, rsp_overflow, rsp_timeout} !== RST_VAL) begin
            n_err++; $display("FAIL abort_state got %h want %h",
                              {cmd_ready, store_a, store_b, start, alu_data, opcode_value,
                               rsp_valid, rsp_result, rsp_overflow, rsp_timeout}, RST_VAL);
        end
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (rsp_valid || start) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", seen);
        end
        do_cmd(8'h10, 8'h01, 2'd1, 2, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 6; i++) begin
            a  = 8'($urandom);
            b  = (i == 2) ? a : 8'($urandom);
            op = 2'($urandom_range(0, 3));
            do_cmd(a, b, op, int'($urandom_range(1, 4)), 1'b0, 0);
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        do_cmd(8'hFF, 8'h01, 2'd0, 2, 1'b0, 0);
        do_cmd(8'h01, 8'h02, 2'd0, 0, 1'b1, 0);
        do_cmd(8'h01, 8'h01, 2'd0, 1, 1'b0, 0);
        n_vec++;
        if ({stat_ops, stat_ovf, stat_tmo} !== {16'd3, 16'd1, 16'd1}) begin
            n_err++; $display("FAIL stats got ops=%0d ovf=%0d tmo=%0d want 3 1 1",
                              stat_ops, stat_ovf, stat_tmo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_backpressure();
        test_timeout();
        test_done_on_last_cycle();
        test_reset_mid_exec();
        test_back_to_back();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
